audio_channel_controller: RTL and testbench
===========================================

// Module: audio_channel_controller
// PURPOSE
//  CPU-facing register bank and sequencer for the 4-channel audio synthesizer (pulse1, pulse2, triangle, noise).
//  Holds each channel's amplitude/period/duty/enable and drives the synthesizer slave's configuration inputs.
//  Runs a frame-tick length counter per channel that auto-silences the channel on expiry, latches a sticky
//  expiry flag and raises an interrupt, so CPU software can play timed notes without polling.
// PARAMETERS
//  FRAME_DIV  208333  CLOCK_50 cycles per frame tick (240 Hz); legal >= 2
//  LEN_W      16      length counter width (frame ticks)
// PORTS
//  CLOCK_50            in   1      system clock; all logic on rising edge
//  reset               in   1      synchronous, active-low (0 = reset)
//  address             in   5      word address: addr[4]=0 -> channel regs (addr[3:2]=chan, addr[1:0]=reg); addr[4]=1 -> global regs
//  write               in   1      single-cycle write strobe
//  writedata           in   32     write data
//  read                in   1      single-cycle read strobe
//  readdata            out  32     read data, valid when readdatavalid=1
//  readdatavalid       out  1      one-cycle pulse, exactly 1 cycle after read
//  irq                 out  1      high while any unmasked expiry flag is set
//  amplitude_<ch>      out  32     per channel (pulse1,pulse2,triangle,noise): amplitude to synth
//  period_<ch>         out  32     per channel: period in cycles to synth
//  duty_cycle_pulse1/2 out  2      pulse duty select
//  enable_<ch>         out  1      per channel: effective enable to synth
// BEHAVIOUR
//  Channel regs (chan 0..3 = pulse1,pulse2,triangle,noise):
//   0 AMPLITUDE [31:0] rw; 1 PERIOD [31:0] rw
//   2 CONTROL  bit0 EN, bits[2:1] DUTY (chan 0/1 only; chans 2/3 write-ignored, read 0), bit3 LEN_EN; other bits read 0
//   3 LENGTH   [LEN_W-1:0]; write loads counter; read returns current remaining count
//  Global regs: 16 STATUS: bits[3:0] sticky expiry flags, write-1-to-clear; 17 MASTER: bit0 MUTE, bits[7:4] IRQ_MASK (1=enable)
//  Global addresses 18..31: writes ignored, reads return 0
//  Reset (reset=0 at clock edge): every register, counter, output, readdata, readdatavalid and irq = 0.
//  Writes take effect at the clock edge of the strobe; outputs change on that edge (0-cycle register->port latency)
//  Reads: readdata captured from address on the read cycle; readdatavalid=1 the next cycle; no side effects
//  Simultaneous read+write to the same address: read returns the pre-write value
//  Frame divider: counter 0..FRAME_DIV-1 wraps; tick is a 1-cycle pulse when counter == FRAME_DIV-1
//  Tick, per channel, if EN & LEN_EN & length != 0: length -= 1
//   If length becomes 0: EN cleared and STATUS[chan] set
//  Tick never decrements when length == 0 (no wrap)
//  CPU write to LENGTH or CONTROL on a tick cycle wins; that channel's decrement is dropped this tick
//  STATUS W1C on the same cycle as a new expiry: flag stays set (set wins)
//  enable_<ch> = EN & ~MUTE & ~(LEN_EN & length==0); MUTE leaves register contents untouched
//  irq = |(STATUS[3:0] & IRQ_MASK), registered (1 cycle after flag set)
//  Reset mid-operation: all state including divider returns to 0; the next tick comes FRAME_DIV cycles after release
// STRUCTURE
//  audio_pkg: channel index constants (CH_PULSE1..CH_NOISE), register offsets, CONTROL/MASTER bit positions
//  Sub-module frame_tick_divider (params FRAME_DIV; ports CLOCK_50, reset, tick)
//  Remainder: register file, length counters, read mux, irq logic in this module
// TESTING (bench overrides FRAME_DIV=4)
//  Reset: hold reset=0 2 cycles -> all outputs 0, irq=0, readdatavalid=0
//  Write addr0=0x1234, addr1=1000, addr2=0x5 -> amplitude_pulse1=0x1234, period_pulse1=1000, duty_cycle_pulse1=2, enable_pulse1=1 next edge
//  Write triangle CONTROL=0x7 -> enable_triangle=1; read addr10 -> readdata=0x1 one cycle later, readdatavalid pulse
//  Pulse1 LENGTH=3, CONTROL=0x9, IRQ_MASK=0x1 -> enable_pulse1 falls on 3rd tick (~12 cycles), STATUS=0x1, irq=1 next cycle; write STATUS=0x1 -> irq=0
//  LENGTH=5 written on a tick cycle -> read LENGTH returns 5; MUTE=1 -> all enable_* 0, regs unchanged; MUTE=0 restores
//  Assert reset=0 while lengths run -> all outputs 0 next edge; after release, no tick for 4 cycles

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants for the audio channel controller: channel indices,
// register offsets and bit positions inside CONTROL and MASTER.
package audio_pkg;

    localparam int NUM_CH = 4;

    // Channel indices (address bits [3:2] of the channel register space)
    localparam logic [1:0] CH_PULSE1   = 2'd0;
    localparam logic [1:0] CH_PULSE2   = 2'd1;
    localparam logic [1:0] CH_TRIANGLE = 2'd2;
    localparam logic [1:0] CH_NOISE    = 2'd3;

    // Per-channel register offsets (address bits [1:0])
    localparam logic [1:0] REG_AMPLITUDE = 2'd0;
    localparam logic [1:0] REG_PERIOD    = 2'd1;
    localparam logic [1:0] REG_CONTROL   = 2'd2;
    localparam logic [1:0] REG_LENGTH    = 2'd3;

    // Global register addresses
    localparam logic [4:0] ADDR_STATUS = 5'd16;
    localparam logic [4:0] ADDR_MASTER = 5'd17;

    // CONTROL bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_DUTY_LSB   = 1;
    localparam int CTRL_LEN_EN_BIT = 3;

    // MASTER bit positions
    localparam int MASTER_MUTE_BIT = 0;
    localparam int MASTER_MASK_LSB = 4;

    // Only the two pulse channels have a duty selector
    function automatic logic chan_has_duty(input logic [1:0] ch);
        return (ch == CH_PULSE1) || (ch == CH_PULSE2);
    endfunction

endpackage

// File: rtl/frame_tick_divider.sv
// Frame tick generator: free-running counter 0..FRAME_DIV-1 that emits a
// one-cycle tick while the counter sits at its last value.
module frame_tick_divider #(
    parameter int FRAME_DIV = 208333
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick
);

    localparam int CW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    // Next counter value with wrap at the last frame cycle
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter and registered tick; tick is high exactly while cnt_q == LAST
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/audio_channel_controller.sv
// CPU register bank and length sequencer for the 4-channel audio synth.
// Holds per-channel amplitude/period/duty/enable, counts note lengths in
// frame ticks, silences expired channels and flags them via STATUS/irq.
module audio_channel_controller
    import audio_pkg::*;
#(
    parameter int FRAME_DIV = 208333,
    parameter int LEN_W     = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [4:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        irq,
    output logic [31:0] amplitude_pulse1,
    output logic [31:0] amplitude_pulse2,
    output logic [31:0] amplitude_triangle,
    output logic [31:0] amplitude_noise,
    output logic [31:0] period_pulse1,
    output logic [31:0] period_pulse2,
    output logic [31:0] period_triangle,
    output logic [31:0] period_noise,
    output logic [1:0]  duty_cycle_pulse1,
    output logic [1:0]  duty_cycle_pulse2,
    output logic        enable_pulse1,
    output logic        enable_pulse2,
    output logic        enable_triangle,
    output logic        enable_noise
);

    logic              tick_s;

    logic [31:0]       amp_q    [NUM_CH];
    logic [31:0]       amp_d    [NUM_CH];
    logic [31:0]       per_q    [NUM_CH];
    logic [31:0]       per_d    [NUM_CH];
    logic [1:0]        duty_q   [NUM_CH];
    logic [1:0]        duty_d   [NUM_CH];
    logic [LEN_W-1:0]  len_q    [NUM_CH];
    logic [LEN_W-1:0]  len_d    [NUM_CH];
    logic [NUM_CH-1:0] en_q,     en_d;
    logic [NUM_CH-1:0] len_en_q, len_en_d;
    logic [NUM_CH-1:0] status_q, status_d;
    logic [NUM_CH-1:0] mask_q,   mask_d;
    logic [NUM_CH-1:0] enable_q, enable_d;
    logic              mute_q,   mute_d;
    logic              irq_q,    irq_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic              rdv_q,    rdv_d;

    logic [NUM_CH-1:0] chan_wr_s;
    logic [NUM_CH-1:0] cpu_owns_s;
    logic [NUM_CH-1:0] expire_s;
    logic [31:0]       rmux_s;

    frame_tick_divider #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_tick_divider (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick     (tick_s)
    );

    // Decode which channel is written and whether the write touches length state
    always_comb begin
        chan_wr_s  = '0;
        cpu_owns_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chan_wr_s[c]  = write & ~address[4] & (address[3:2] == 2'(c));
            cpu_owns_s[c] = chan_wr_s[c] &
                            ((address[1:0] == REG_CONTROL) || (address[1:0] == REG_LENGTH));
        end
    end

    // Channel register writes and length countdown; a CPU write to
    // CONTROL/LENGTH takes priority over that channel's tick decrement
    always_comb begin
        amp_d    = amp_q;
        per_d    = per_q;
        duty_d   = duty_q;
        len_d    = len_q;
        en_d     = en_q;
        len_en_d = len_en_q;
        expire_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            amp_d[c] = (chan_wr_s[c] && (address[1:0] == REG_AMPLITUDE)) ? writedata : amp_q[c];
            per_d[c] = (chan_wr_s[c] && (address[1:0] == REG_PERIOD))    ? writedata : per_q[c];
            if (cpu_owns_s[c]) begin
                if (address[1:0] == REG_CONTROL) begin
                    en_d[c]     = writedata[CTRL_EN_BIT];
                    len_en_d[c] = writedata[CTRL_LEN_EN_BIT];
                    duty_d[c]   = chan_has_duty(2'(c)) ? writedata[CTRL_DUTY_LSB +: 2] : 2'b00;
                end else begin
                    len_d[c] = writedata[LEN_W-1:0];
                end
            end else if (tick_s && en_q[c] && len_en_q[c] && (len_q[c] != '0)) begin
                len_d[c] = len_q[c] - LEN_W'(1);
                if (len_q[c] == LEN_W'(1)) begin
                    en_d[c]     = 1'b0;
                    expire_s[c] = 1'b1;
                end else begin
                    expire_s[c] = 1'b0;
                end
            end else begin
                expire_s[c] = 1'b0;
            end
        end
    end

    // Global registers, irq and effective channel enables (new expiry beats W1C)
    always_comb begin
        status_d = status_q;
        mute_d   = mute_q;
        mask_d   = mask_q;
        if (write && (address == ADDR_STATUS)) begin
            status_d = status_q & ~writedata[NUM_CH-1:0];
        end else begin
            status_d = status_q;
        end
        status_d = status_d | expire_s;
        if (write && (address == ADDR_MASTER)) begin
            mute_d = writedata[MASTER_MUTE_BIT];
            mask_d = writedata[MASTER_MASK_LSB +: NUM_CH];
        end else begin
            mute_d = mute_q;
            mask_d = mask_q;
        end
        irq_d = |(status_q & mask_q);
        for (int c = 0; c < NUM_CH; c++) begin
            enable_d[c] = en_d[c] & ~mute_d & ~(len_en_d[c] & (len_d[c] == '0));
        end
    end

    // Read mux over the pre-write register contents
    always_comb begin
        rmux_s = 32'h0000_0000;
        if (!address[4]) begin
            case (address[1:0])
                REG_AMPLITUDE: rmux_s = amp_q[address[3:2]];
                REG_PERIOD:    rmux_s = per_q[address[3:2]];
                REG_CONTROL:   rmux_s = {28'h000_0000, len_en_q[address[3:2]],
                                         duty_q[address[3:2]], en_q[address[3:2]]};
                REG_LENGTH:    rmux_s = 32'(len_q[address[3:2]]);
                default:       rmux_s = 32'h0000_0000;
            endcase
        end else begin
            case (address)
                ADDR_STATUS: rmux_s = {28'h000_0000, status_q};
                ADDR_MASTER: rmux_s = {24'h00_0000, mask_q, 3'b000, mute_q};
                default:     rmux_s = 32'h0000_0000;
            endcase
        end
        if (read) begin
            rdata_d = rmux_s;
        end else begin
            rdata_d = rdata_q;
        end
        rdv_d = read;
    end

    // State register with synchronous active-low reset
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                amp_q[c]  <= '0;
                per_q[c]  <= '0;
                duty_q[c] <= '0;
                len_q[c]  <= '0;
            end
            en_q     <= '0;
            len_en_q <= '0;
            status_q <= '0;
            mask_q   <= '0;
            enable_q <= '0;
            mute_q   <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rdv_q    <= 1'b0;
        end else begin
            amp_q    <= amp_d;
            per_q    <= per_d;
            duty_q   <= duty_d;
            len_q    <= len_d;
            en_q     <= en_d;
            len_en_q <= len_en_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            enable_q <= enable_d;
            mute_q   <= mute_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            rdv_q    <= rdv_d;
        end
    end

    assign readdata           = rdata_q;
    assign readdatavalid      = rdv_q;
    assign irq                = irq_q;
    assign amplitude_pulse1   = amp_q[CH_PULSE1];
    assign amplitude_pulse2   = amp_q[CH_PULSE2];
    assign amplitude_triangle = amp_q[CH_TRIANGLE];
    assign amplitude_noise    = amp_q[CH_NOISE];
    assign period_pulse1      = per_q[CH_PULSE1];
    assign period_pulse2      = per_q[CH_PULSE2];
    assign period_triangle    = per_q[CH_TRIANGLE];
    assign period_noise       = per_q[CH_NOISE];
    assign duty_cycle_pulse1  = duty_q[CH_PULSE1];
    assign duty_cycle_pulse2  = duty_q[CH_PULSE2];
    assign enable_pulse1      = enable_q[CH_PULSE1];
    assign enable_pulse2      = enable_q[CH_PULSE2];
    assign enable_triangle    = enable_q[CH_TRIANGLE];
    assign enable_noise       = enable_q[CH_NOISE];

endmodule

// File: tb/tb_audio_channel_controller.sv
// Testbench for audio_channel_controller: directed and random CPU traffic
// against a behavioural model; read responses go through a scoreboard queue.
module tb_audio_channel_controller;

    localparam int FDIV = 4;
    localparam int LW   = 16;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [4:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        irq;
    logic [31:0] amplitude_pulse1, amplitude_pulse2, amplitude_triangle, amplitude_noise;
    logic [31:0] period_pulse1, period_pulse2, period_triangle, period_noise;
    logic [1:0]  duty_cycle_pulse1, duty_cycle_pulse2;
    logic        enable_pulse1, enable_pulse2, enable_triangle, enable_noise;

    always #5 CLOCK_50 = ~CLOCK_50;

    audio_channel_controller #(.FRAME_DIV(FDIV), .LEN_W(LW)) dut (
        .CLOCK_50           (CLOCK_50),
        .reset              (reset),
        .address            (address),
        .write              (write),
        .writedata          (writedata),
        .read               (read),
        .readdata           (readdata),
        .readdatavalid      (readdatavalid),
        .irq                (irq),
        .amplitude_pulse1   (amplitude_pulse1),
        .amplitude_pulse2   (amplitude_pulse2),
        .amplitude_triangle (amplitude_triangle),
        .amplitude_noise    (amplitude_noise),
        .period_pulse1      (period_pulse1),
        .period_pulse2      (period_pulse2),
        .period_triangle    (period_triangle),
        .period_noise       (period_noise),
        .duty_cycle_pulse1  (duty_cycle_pulse1),
        .duty_cycle_pulse2  (duty_cycle_pulse2),
        .enable_pulse1      (enable_pulse1),
        .enable_pulse2      (enable_pulse2),
        .enable_triangle    (enable_triangle),
        .enable_noise       (enable_noise)
    );

    // Behavioural model state (value after the most recent clock edge)
    logic [31:0] m_amp [4];
    logic [31:0] m_per [4];
    logic [1:0]  m_duty [4];
    logic [15:0] m_len [4];
    logic        m_en [4];
    logic        m_lenen [4];
    logic [3:0]  m_status, m_mask;
    logic        m_mute, m_irq, m_rdv;
    int          m_frame;          // cycles since reset release

    logic [31:0] exp_q[$];         // scoreboard of expected read data
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          checking = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        int c;
        c = int'(a[3:2]);
        if (a < 5'd16) begin
            case (a[1:0])
                2'd0:    return m_amp[c];
                2'd1:    return m_per[c];
                2'd2:    return {28'd0, m_lenen[c], m_duty[c], m_en[c]};
                default: return {16'd0, m_len[c]};
            endcase
        end
        if (a == 5'd16) return {28'd0, m_status};
        if (a == 5'd17) return {24'd0, m_mask, 3'd0, m_mute};
        return 32'd0;
    endfunction

    function automatic logic [3:0] exp_enable();
        logic [3:0] e;
        for (int c = 0; c < 4; c++)
            e[c] = m_en[c] && !m_mute && !(m_lenen[c] && (m_len[c] == 16'd0));
        return e;
    endfunction

    // One bus cycle: drive inputs, advance the model across the next edge
    task automatic cyc(input bit w, input logic [4:0] a, input logic [31:0] d, input bit r);
        logic [31:0] n_amp [4];
        logic [31:0] n_per [4];
        logic [1:0]  n_duty [4];
        logic [15:0] n_len [4];
        logic        n_en [4];
        logic        n_lenen [4];
        logic [3:0]  n_status, n_mask, set;
        logic        n_mute;
        bit          tick, owned, chw;
        write = w; address = a; writedata = d; read = r;
        n_amp = m_amp; n_per = m_per; n_duty = m_duty; n_len = m_len;
        n_en = m_en; n_lenen = m_lenen; n_mask = m_mask; n_mute = m_mute;
        set = 4'd0;
        tick = ((m_frame % FDIV) == FDIV - 1);
        for (int c = 0; c < 4; c++) begin
            chw   = w && (a < 5'd16) && (int'(a[3:2]) == c);
            owned = chw && (a[1:0] >= 2'd2);
            if (chw) begin
                case (a[1:0])
                    2'd0: n_amp[c] = d;
                    2'd1: n_per[c] = d;
                    2'd2: begin
                        n_en[c]    = d[0];
                        n_lenen[c] = d[3];
                        n_duty[c]  = (c < 2) ? d[2:1] : 2'd0;
                    end
                    default: n_len[c] = d[15:0];
                endcase
            end
            if (!owned && tick && m_en[c] && m_lenen[c] && m_len[c] != 16'd0) begin
                n_len[c] = m_len[c] - 16'd1;
                if (n_len[c] == 16'd0) begin
                    n_en[c] = 1'b0;
                    set[c]  = 1'b1;
                end
            end
        end
        n_status = m_status;
        if (w && a == 5'd16) n_status = n_status & ~d[3:0];
        n_status = n_status | set;
        if (w && a == 5'd17) begin
            n_mute = d[0];
            n_mask = d[7:4];
        end
        if (reset && r) exp_q.push_back(model_read(a));
        @(posedge CLOCK_50);
        if (!reset) begin
            for (int c = 0; c < 4; c++) begin
                m_amp[c] = 32'd0; m_per[c] = 32'd0; m_duty[c] = 2'd0; m_len[c] = 16'd0;
                m_en[c] = 1'b0; m_lenen[c] = 1'b0;
            end
            m_status = 4'd0; m_mask = 4'd0; m_mute = 1'b0; m_irq = 1'b0; m_rdv = 1'b0;
            m_frame = 0;
            exp_q.delete();
        end else begin
            m_irq = |(m_status & m_mask);
            m_amp = n_amp; m_per = n_per; m_duty = n_duty; m_len = n_len;
            m_en = n_en; m_lenen = n_lenen; m_status = n_status; m_mask = n_mask;
            m_mute = n_mute; m_rdv = r;
            m_frame++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    // Monitor: compare outputs with the model and pop read responses
    always @(negedge CLOCK_50) begin
        if (checking) begin
            chk("enable", {28'd0, enable_noise, enable_triangle, enable_pulse2, enable_pulse1},
                {28'd0, exp_enable()});
            chk("amp_pulse1", amplitude_pulse1, m_amp[0]);
            chk("amp_pulse2", amplitude_pulse2, m_amp[1]);
            chk("amp_triangle", amplitude_triangle, m_amp[2]);
            chk("amp_noise", amplitude_noise, m_amp[3]);
            chk("period_pulse1", period_pulse1, m_per[0]);
            chk("period_pulse2", period_pulse2, m_per[1]);
            chk("period_triangle", period_triangle, m_per[2]);
            chk("period_noise", period_noise, m_per[3]);
            chk("duty", {28'd0, duty_cycle_pulse2, duty_cycle_pulse1}, {28'd0, m_duty[1], m_duty[0]});
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
            chk("readdatavalid", {31'd0, readdatavalid}, {31'd0, m_rdv});
            if (readdatavalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL readdata: unexpected response 0x%0h, none expected", readdata);
                end else begin
                    chk("readdata", readdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [4:0]  a;
        logic [31:0] d;
        bit          w, r;
        reset = 1'b0; write = 1'b0; read = 1'b0; address = 5'd0; writedata = 32'd0;
        idle(2);
        reset = 1'b1;
        checking = 1'b1;

        // Reset readback of every defined address plus an unmapped one
        for (int i = 0; i < 18; i++) cyc(1'b0, 5'(i), 32'd0, 1'b1);
        cyc(1'b0, 5'd25, 32'd0, 1'b1);

        // Pulse1 basic configuration
        cyc(1'b1, 5'd0, 32'h1234, 1'b0);
        cyc(1'b1, 5'd1, 32'd1000, 1'b0);
        cyc(1'b1, 5'd2, 32'h5, 1'b0);
        // Triangle CONTROL: duty bits ignored, readback shows only EN
        cyc(1'b1, 5'd10, 32'h7, 1'b0);
        cyc(1'b0, 5'd10, 32'd0, 1'b1);
        idle(1);

        // Pulse1 timed note with irq enabled, then W1C
        cyc(1'b1, 5'd3, 32'd3, 1'b0);
        cyc(1'b1, 5'd2, 32'h9, 1'b0);
        cyc(1'b1, 5'd17, 32'h10, 1'b0);
        idle(16);
        cyc(1'b0, 5'd16, 32'd0, 1'b1);
        cyc(1'b1, 5'd16, 32'h1, 1'b0);
        idle(3);

        // LENGTH written exactly on a tick cycle: write wins
        cyc(1'b1, 5'd7, 32'd10, 1'b0);
        cyc(1'b1, 5'd6, 32'h9, 1'b0);
        while ((m_frame % FDIV) != FDIV - 1) idle(1);
        cyc(1'b1, 5'd7, 32'd5, 1'b0);
        cyc(1'b0, 5'd7, 32'd0, 1'b1);

        // Read and write of the same address in one cycle returns old value
        cyc(1'b1, 5'd4, 32'hABCD_0123, 1'b1);
        cyc(1'b0, 5'd4, 32'd0, 1'b1);
        // Unmapped global write ignored
        cyc(1'b1, 5'd20, 32'hFFFF_FFFF, 1'b0);
        cyc(1'b0, 5'd20, 32'd0, 1'b1);

        // MUTE silences everything without touching registers
        cyc(1'b1, 5'd17, 32'h11, 1'b0);
        idle(2);
        cyc(1'b0, 5'd0, 32'd0, 1'b1);
        cyc(1'b0, 5'd6, 32'd0, 1'b1);
        cyc(1'b0, 5'd17, 32'd0, 1'b1);
        cyc(1'b1, 5'd17, 32'h10, 1'b0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 17));
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            d = $urandom;
            if (a < 5'd16 && a[1:0] == 2'd3) d = 32'($urandom_range(0, 6));
            if (a < 5'd16 && a[1:0] == 2'd2) d = ($urandom_range(0, 3) == 0) ? d : 32'h9;
            if (a == 5'd17) d = (d & 32'hF0) | 32'(($urandom_range(0, 7) == 0) ? 1 : 0);
            cyc(w, a, d, r);
        end

        // Reset while lengths are running, then check tick spacing after release
        cyc(1'b1, 5'd15, 32'd4, 1'b0);
        cyc(1'b1, 5'd14, 32'h9, 1'b0);
        idle(2);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        cyc(1'b1, 5'd3, 32'd2, 1'b0);
        cyc(1'b1, 5'd2, 32'h9, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 5'd3, 32'd0, 1'b1);
        idle(3);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
